// File: rtl/k6502_pkg.sv
// Shared types and constants for the k6502 timing front-end.
package k6502_pkg;

  // Interrupt source attached to the instruction sequence currently running.
  typedef enum logic [1:0] {
    INT_NONE = 2'd0,
    INT_RES  = 2'd1,
    INT_NMI  = 2'd2,
    INT_IRQ  = 2'd3
  } int_src_t;

  // Bit positions of the one-hot T-state vector.
  localparam int unsigned T1 = 0;
  localparam int unsigned T2 = 1;
  localparam int unsigned T3 = 2;
  localparam int unsigned T4 = 3;
  localparam int unsigned T5 = 4;
  localparam int unsigned T6 = 5;

  localparam logic [7:0] BRK_OPCODE_DEFAULT = 8'h00;

  // KIL opcodes: 02,12,22,32,42,52,62,72,92,B2,D2,F2 (x2 except 82,A2,C2,E2).
  function automatic logic is_kil(input logic [7:0] op);
    logic not_kil_hi;
    not_kil_hi = (op[7:4] == 4'h8) || (op[7:4] == 4'hA) ||
                 (op[7:4] == 4'hC) || (op[7:4] == 4'hE);
    return (op[3:0] == 4'h2) && !not_kil_hi;
  endfunction

endpackage

// File: rtl/k6502_int_latch.sv
// Interrupt capture and arbitration: NMI falling-edge detect, IRQ sampling,
// RES/NMI pending flags and the priority choice latched on T1 entry.
module k6502_int_latch
  import k6502_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     boundary,  // clk edge ending a ph2 clk
  input  logic     enter_t1,  // sequencer advances into T1 at this boundary
  input  logic     res_done,  // reset BRK has just been latched into IR
  input  logic     nmi_n,
  input  logic     irq_n,
  input  logic     i_flag,
  output int_src_t int_src
);

  logic     nmi_prev_q, nmi_prev_d;
  logic     nmi_pend_q, nmi_pend_d;
  logic     res_pend_q, res_pend_d;
  logic     irq_q, irq_d;
  logic     nmi_edge;
  int_src_t int_src_q, int_src_d;
  int_src_t sel;

  // Fixed priority RES > NMI > unmasked IRQ.
  always_comb begin
    sel = INT_NONE;
    if (res_pend_q) begin
      sel = INT_RES;
    end else if (nmi_pend_q) begin
      sel = INT_NMI;
    end else if (irq_q && !i_flag) begin
      sel = INT_IRQ;
    end
  end

  // Next-state for sampling, pendings and the selected source.
  always_comb begin
    nmi_prev_d = nmi_prev_q;
    nmi_pend_d = nmi_pend_q;
    res_pend_d = res_pend_q;
    irq_d      = irq_q;
    int_src_d  = int_src_q;
    nmi_edge   = nmi_prev_q & ~nmi_n;
    if (boundary) begin
      nmi_prev_d = nmi_n;
      irq_d      = ~irq_n;
      if (enter_t1) begin
        int_src_d = sel;
      end
      // The reset request is consumed once its BRK is in IR, so it runs only once.
      res_pend_d = res_pend_q & ~res_done & ~(enter_t1 & (sel == INT_RES));
      // A fresh edge on the servicing boundary stays pending for the next instruction.
      nmi_pend_d = (nmi_pend_q & ~(enter_t1 & (sel == INT_NMI))) | nmi_edge;
    end
  end

  // Interrupt state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_prev_q <= 1'b1;
      nmi_pend_q <= 1'b0;
      res_pend_q <= 1'b1;
      irq_q      <= 1'b0;
      int_src_q  <= INT_RES;
    end else begin
      nmi_prev_q <= nmi_prev_d;
      nmi_pend_q <= nmi_pend_d;
      res_pend_q <= res_pend_d;
      irq_q      <= irq_d;
      int_src_q  <= int_src_d;
    end
  end

  assign int_src = int_src_q;

endmodule

// File: rtl/k6502_timing.sv
// k6502 cycle timing and instruction register front-end: ph1/ph2 generation,
// T1..T6 sequencing, IR load and forced-BRK interrupt entry.
// Optional: define K6502_JAM_EN to halt on KIL opcodes.
module k6502_timing
  import k6502_pkg::*;
#(
  parameter logic [7:0] BRK_OPCODE = BRK_OPCODE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy,
  input  logic [7:0] pd,
  input  logic       t_end,
  input  logic       i_flag,
  input  logic       nmi_n,
  input  logic       irq_n,
  output logic       ph1,
  output logic       ph2,
  output logic       sync,
  output logic [7:0] ir,
  output logic [5:0] tstate,
  output int_src_t   int_src,
  output logic       pc_inc_inhibit,
  output logic       jam
);

  logic       ph1_q, ph1_d;
  logic       ph2_q, ph2_d;
  logic       rdy_q, rdy_d;
  logic [5:0] tstate_q, tstate_d;
  logic [7:0] ir_q, ir_d;
  logic       jam_q, jam_d;
  logic       adv;
  logic       kil_load;
  logic       enter_t1;
  logic       res_done;

  // Phase generator: idle after reset, then ph1, ph2, ph1, ... with no gaps.
  always_comb begin
    ph1_d = ~ph1_q;
    ph2_d = ph1_q;
    rdy_d = ph1_q ? rdy : rdy_q;
  end

  // Sequencer moves only on a ready, non-jammed cycle boundary.
  assign adv = ph2_q & rdy_q & ~jam_q;

  // KIL detection on the IR-load boundary.
  always_comb begin
`ifdef K6502_JAM_EN
    kil_load = adv & tstate_q[T1] & (int_src == INT_NONE) & is_kil(pd);
    jam_d    = jam_q | kil_load;
`else
    kil_load = 1'b0;
    jam_d    = 1'b0;
`endif
  end

  // T-state advance and IR load.
  always_comb begin
    tstate_d = tstate_q;
    ir_d     = ir_q;
    if (adv) begin
      if (t_end || tstate_q[T6]) begin
        tstate_d = 6'b000001;
      end else begin
        tstate_d = {tstate_q[4:0], 1'b0};
      end
      if (tstate_q[T1]) begin
        ir_d = (int_src == INT_NONE) ? pd : BRK_OPCODE;
      end
      if (kil_load) begin
        tstate_d = 6'b000010;
      end
    end
  end

  assign enter_t1 = adv & tstate_d[T1];
  assign res_done = adv & tstate_q[T1] & (int_src == INT_RES);

  // Timing and sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph1_q    <= 1'b0;
      ph2_q    <= 1'b0;
      rdy_q    <= 1'b1;
      tstate_q <= 6'b000001;
      ir_q     <= BRK_OPCODE;
      jam_q    <= 1'b0;
    end else begin
      ph1_q    <= ph1_d;
      ph2_q    <= ph2_d;
      rdy_q    <= rdy_d;
      tstate_q <= tstate_d;
      ir_q     <= ir_d;
      jam_q    <= jam_d;
    end
  end

  k6502_int_latch u_int_latch (
    .clk      (clk),
    .rst_n    (rst_n),
    .boundary (ph2_q),
    .enter_t1 (enter_t1),
    .res_done (res_done),
    .nmi_n    (nmi_n),
    .irq_n    (irq_n),
    .i_flag   (i_flag),
    .int_src  (int_src)
  );

  assign ph1            = ph1_q;
  assign ph2            = ph2_q;
  // Phases are both low only while idle after reset, which gates sync.
  assign sync           = tstate_q[T1] & (ph1_q | ph2_q);
  assign ir             = ir_q;
  assign tstate         = tstate_q;
  assign pc_inc_inhibit = (int_src != INT_NONE) & (tstate_q[T1] | tstate_q[T2]);
  assign jam            = jam_q;

endmodule
